// File: rtl/clock_init_sequencer_pkg.sv
// xm23_clk_pkg: shared state encoding and default constants for the clock/init sequencer
package xm23_clk_pkg;
  typedef enum logic [1:0] {
    FORCE = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10
  } state_t;
  localparam int DFLT_DIV = 3;
  localparam logic [14:0] DFLT_FORCE_VALUE = 15'h7FFF;
endpackage

// File: rtl/clock_init_sequencer_if.sv
// clock_init_sequencer_if: control inputs and tick/force/status outputs of the sequencer
interface clock_init_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 15
);
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic                    run_i;
  logic                    step_i;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       clk_o;
  logic                    force_o;
  logic [ADDR_W-1:0]       force_addr_o;
  logic [1:0]              state_o;
  logic                    led_o;
  modport master (
    output div_i, run_i, step_i,
    input  tick_o, clk_o, force_o, force_addr_o, state_o, led_o
  );
  modport slave (
    input  div_i, run_i, step_i,
    output tick_o, clk_o, force_o, force_addr_o, state_o, led_o
  );
endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with period-aligned divide latch, gated tick and square wave
module clk_div_channel
  import xm23_clk_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = DFLT_DIV
) (
  input  logic             clk_in,
  input  logic             init,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             wrap,
  output logic             tick,
  output logic             sq
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] lim;
  assign lim  = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign wrap = cnt == lim;
  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      cnt   <= '0;
      div_q <= DIV_W'(DEFAULT_DIV);
      tick  <= 1'b0;
      sq    <= 1'b0;
    end else begin
      cnt   <= wrap ? '0 : cnt + DIV_W'(1);
      div_q <= wrap ? div : div_q;
      tick  <= wrap & en;
      sq    <= sq ^ (wrap & en);
    end
  end
endmodule

// File: rtl/clock_init_sequencer.sv
// clock_init_sequencer: multi-channel clock enables with PC-force init, run/halt/step gating and heartbeat
module clock_init_sequencer
  import xm23_clk_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                DIV_W       = 16,
  parameter int                DEFAULT_DIV = DFLT_DIV,
  parameter int                FORCE_TICKS = 1,
  parameter int                ADDR_W      = 15,
  parameter logic [ADDR_W-1:0] FORCE_VALUE = DFLT_FORCE_VALUE,
  parameter int                LED_TICKS   = 1
) (
  input logic                   clk_in,
  input logic                   init,
  clock_init_sequencer_if.slave bus
);
  localparam int FW = $clog2(FORCE_TICKS + 1);
  localparam int LW = $clog2(LED_TICKS + 1);
  state_t            state, state_n;
  logic [FW-1:0]     force_cnt, force_cnt_n;
  logic [LW-1:0]     led_cnt, led_cnt_n;
  logic              led_q, led_n;
  logic              step_prev, step_pend, step_pend_n;
  logic              step_edge, pass, force_last, led_last;
  logic [NUM_CH-1:0] wrap, en, tick, sq;
  logic              unused_wrap;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      clk_div_channel #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
      ) u_ch (
        .clk_in(clk_in),
        .init  (init),
        .div   (bus.div_i[c*DIV_W +: DIV_W]),
        .en    (en[c]),
        .wrap  (wrap[c]),
        .tick  (tick[c]),
        .sq    (sq[c])
      );
    end
  endgenerate
  assign unused_wrap = ^wrap;
  assign step_edge   = bus.step_i & ~step_prev;
  assign pass        = wrap[0] & en[0];
  assign force_last  = force_cnt == FW'(FORCE_TICKS - 1);
  assign led_last    = led_cnt == LW'(LED_TICKS - 1);
  always_comb begin
    en          = '1;
    en[0]       = (state != HALT) || step_pend;
    state_n     = (state == FORCE) ? ((pass && force_last) ? (bus.run_i ? RUN : HALT) : FORCE)
                                   : (bus.run_i ? RUN : HALT);
    force_cnt_n = (state == FORCE && pass) ? force_cnt + FW'(1) : force_cnt;
    led_cnt_n   = pass ? (led_last ? '0 : led_cnt + LW'(1)) : led_cnt;
    led_n       = led_q ^ (pass && led_last);
    step_pend_n = (state_n == RUN) ? 1'b0
                : (state == HALT) ? (step_pend ? !wrap[0] : step_edge)
                : step_pend;
  end
  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      state     <= FORCE;
      force_cnt <= '0;
      led_cnt   <= '0;
      led_q     <= 1'b0;
      step_prev <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      state     <= state_n;
      force_cnt <= force_cnt_n;
      led_cnt   <= led_cnt_n;
      led_q     <= led_n;
      step_prev <= bus.step_i;
      step_pend <= step_pend_n;
    end
  end
  assign bus.tick_o       = tick;
  assign bus.clk_o        = sq;
  assign bus.state_o      = state;
  assign bus.force_o      = state == FORCE;
  assign bus.force_addr_o = (state == FORCE) ? FORCE_VALUE : '0;
  assign bus.led_o        = led_q;
endmodule

// File: tb/tb_clock_init_sequencer.sv
// tb_clock_init_sequencer: directed checks of dividers, force release, halt/step, div 0/1 and async init
module tb_clock_init_sequencer;
  logic clk_in;
  logic init;
  int   n_cmp;
  int   n_err;
  int   edge_n;
  int   pulses;
  int   first;
  int   cnt;
  logic prev;
  logic found;
  logic [22:0] rst_v;
  clock_init_sequencer_if #(.NUM_CH(2), .DIV_W(16), .ADDR_W(15)) ifa ();
  clock_init_sequencer_if #(.NUM_CH(2), .DIV_W(16), .ADDR_W(15)) ifb ();
  clock_init_sequencer #(
    .NUM_CH(2), .DIV_W(16), .DEFAULT_DIV(3), .FORCE_TICKS(1),
    .ADDR_W(15), .FORCE_VALUE(15'h7FFF), .LED_TICKS(1)
  ) u_a (
    .clk_in(clk_in),
    .init  (init),
    .bus   (ifa)
  );
  clock_init_sequencer #(
    .NUM_CH(2), .DIV_W(16), .DEFAULT_DIV(3), .FORCE_TICKS(3),
    .ADDR_W(15), .FORCE_VALUE(15'h7FFF), .LED_TICKS(2)
  ) u_b (
    .clk_in(clk_in),
    .init  (init),
    .bus   (ifb)
  );
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick_clk();
    @(posedge clk_in);
    #1;
    edge_n++;
  endtask
  function automatic logic [22:0] va();
    return {ifa.force_addr_o, ifa.tick_o, ifa.clk_o, ifa.force_o, ifa.state_o, ifa.led_o};
  endfunction
  function automatic logic [22:0] vb();
    return {ifb.force_addr_o, ifb.tick_o, ifb.clk_o, ifb.force_o, ifb.state_o, ifb.led_o};
  endfunction
  function automatic logic [22:0] exp_vec(logic t, logic c, logic f, logic [1:0] s, logic l);
    return {f ? 15'h7FFF : 15'h0000, t, t, c, c, f, s, l};
  endfunction
  task automatic seq_check(input string ph);
    check({ph, "_rst_a"}, va(), rst_v);
    check({ph, "_rst_b"}, vb(), rst_v);
    @(negedge clk_in);
    init   = 1'b0;
    edge_n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick_clk();
      check($sformatf("%s_a_e%0d", ph, k), va(),
            exp_vec(k % 3 == 0, (k / 3) % 2 == 1, k < 3, (k < 3) ? 2'b00 : 2'b01, (k / 3) % 2 == 1));
      check($sformatf("%s_b_e%0d", ph, k), vb(),
            exp_vec(k % 3 == 0, (k / 3) % 2 == 1, k < 9, (k < 9) ? 2'b00 : 2'b01, k >= 6 && k < 12));
    end
  endtask
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    edge_n     = 0;
    rst_v      = exp_vec(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    init       = 1'b1;
    ifa.div_i  = {16'd3, 16'd3};
    ifa.run_i  = 1'b1;
    ifa.step_i = 1'b0;
    ifb.div_i  = {16'd3, 16'd3};
    ifb.run_i  = 1'b1;
    ifb.step_i = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    seq_check("boot");
    ifa.div_i[31:16] = 16'd5;
    repeat (14) begin
      tick_clk();
      check($sformatf("div_chg_e%0d", edge_n), {30'd0, ifa.tick_o},
            {30'd0, edge_n == 15 || edge_n == 20 || edge_n == 25, edge_n % 3 == 0});
    end
    ifa.run_i = 1'b0;
    tick_clk();
    check("halt_entry_tick", {29'd0, ifa.tick_o[0], ifa.state_o}, 32'b110);
    pulses = 0;
    repeat (50) begin
      tick_clk();
      pulses += int'(ifa.tick_o[0]);
    end
    check("halt_quiet", pulses, 0);
    ifa.step_i = 1'b1;
    pulses = 0;
    first  = 0;
    repeat (12) begin
      tick_clk();
      if (ifa.tick_o[0]) begin
        pulses++;
        if (first == 0) first = edge_n;
      end
      if (edge_n == 80) ifa.step_i = 1'b0;
    end
    check("step1_count", pulses, 1);
    check("step1_edge", first, 81);
    pulses = 0;
    first  = 0;
    repeat (21) begin
      tick_clk();
      if (ifa.tick_o[0]) begin
        pulses++;
        if (first == 0) first = edge_n;
      end
      if (edge_n == 90 || edge_n == 92) ifa.step_i = 1'b1;
      if (edge_n == 91 || edge_n == 94) ifa.step_i = 1'b0;
    end
    check("step2_count", pulses, 1);
    check("step2_edge", first, 93);
    check("halt_state", {30'd0, ifa.state_o}, 32'd2);
    ifa.run_i       = 1'b1;
    ifa.div_i[15:0] = 16'd0;
    tick_clk();
    check("run_resume", {30'd0, ifa.state_o}, 32'd1);
    for (int p = 0; p < 2; p++) begin
      prev = ifa.clk_o[0];
      cnt  = 0;
      repeat (6) begin
        tick_clk();
        if (ifa.tick_o[0] && ifa.clk_o[0] != prev) cnt++;
        prev = ifa.clk_o[0];
      end
      check($sformatf("div%0d_every_cycle", p), cnt, 6);
      ifa.div_i[15:0] = 16'd1;
    end
    ifa.div_i = {16'd3, 16'd3};
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      if (ifa.clk_o[0]) found = 1'b1;
      else tick_clk();
    end
    check("clk_hi_wait", {31'd0, found}, 32'd1);
    #2;
    init = 1'b1;
    #1;
    check("async_rst_a", va(), rst_v);
    check("async_rst_b", vb(), rst_v);
    seq_check("rerun");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_init_sequencer.md
# clock_init_sequencer

Parametrised clock-enable and init sequencer for the XM23 core. It replaces the single fixed divider and PC-force logic in the top level. It generates NUM_CH independent divided tick/square-wave outputs from the 50 MHz input, and holds the program-RAM address force through a configurable number of core ticks after init. It also adds run/halt with single-step on the core channel (channel 0), plus a heartbeat LED.

## Interface
- NUM_CH, 2, number of divider channels; channel 0 is the core clock
- DIV_W, 16, width of each divide value
- DEFAULT_DIV, 3, divide value loaded into every channel at reset
- FORCE_TICKS, 1, channel-0 ticks issued while the PC force is held (≥1)
- ADDR_W, 15, width of the force address
- FORCE_VALUE, 15'h7FFF, word address ORed into the p_ram address during force
- LED_TICKS, 1, core ticks per LED toggle (≥1)

Ports:
- clk_in  in  1  50 MHz clock; all logic is on its rising edge
- init  in  1  reset, asynchronous, active-high
- div_i  in  NUM_CH×DIV_W  per-channel divide value; 0 is treated as 1
- run_i  in  1  1 = core channel runs freely, 0 = halt
- step_i  in  1  level; a rising edge requests one core tick while halted
- tick_o  out  NUM_CH  one-cycle pulse, once per divide period (after gating on channel 0)
- clk_o  out  NUM_CH  square wave; toggles on every tick_o pulse
- force_o  out  1  PC force active
- force_addr_o  out  ADDR_W  FORCE_VALUE while force_o = 1, else 0
- state_o  out  2  00 FORCE, 01 RUN, 10 HALT (11 unused)
- led_o  out  1  heartbeat

## Operation
- Each channel has a counter cnt and a latched divide value div_q.
  - Reset: cnt = 0, div_q = DEFAULT_DIV.
  - Wrap: cnt == max(div_q,1)−1. On wrap, cnt ← 0 and div_q ← div_i[ch], so a new divide value takes effect only on a period boundary.
  - Otherwise cnt ← cnt+1.
  - A wrap registers a raw tick, giving a tick_o pulse in the following cycle.
- Channels 1..NUM_CH−1 are never gated: tick_o[ch] is the raw tick.
- Channel 0 always counts. Its raw tick is passed to tick_o[0] and clk_o[0] only as follows:
  - FORCE: every raw tick passes.
  - RUN: every raw tick passes.
  - HALT: a raw tick passes only if step_pend = 1, and that tick clears step_pend.
- step_pend:
  - Set in HALT on a rising edge of step_i (previous-cycle sample = 0, current = 1).
  - A second edge while pending is ignored.
  - Cleared on entry to RUN.
- FSM (registered, reset to FORCE):
  - FORCE: force_cnt counts passed channel-0 ticks. On the FORCE_TICKS-th tick, go to RUN if run_i = 1, else HALT.
  - RUN → HALT when run_i = 0.
  - HALT → RUN when run_i = 1.
  - run_i is ignored in FORCE.
- force_o = 1 exactly while state = FORCE. force_addr_o = force_o ? FORCE_VALUE : 0.
- led_o toggles every LED_TICKS passed channel-0 ticks, using a wrap-around counter.

## Timing
- Reset values while init = 1:
  - tick_o = 0, clk_o = 0, led_o = 0
  - force_o = 1, force_addr_o = FORCE_VALUE, state_o = 00
  - all counters = 0, step_pend = 0
- First tick: with div = D, the first tick_o pulse rises on the D-th clk_in edge after init falls, then repeats every D cycles. D = 1 gives tick_o constantly high and clk_o toggling every cycle.
- clk_o toggles on the same edge that tick_o rises, so its period is 2·D cycles.
- force_o falls, and state_o leaves FORCE, on the same edge as the FORCE_TICKS-th channel-0 tick_o rise.
- A run_i change is seen one edge later (registered state). A raw tick that coincides with the RUN→HALT edge still passes.
- Step edge and raw tick in the same cycle: the tick does not pass; it passes on the next wrap.
- If init is asserted mid-operation, all state returns to reset values immediately (asynchronous). No partial tick pulse is produced after release.

## Structure
- Package xm23_clk_pkg holds:
  - the state enum (FORCE = 2'b00, RUN = 2'b01, HALT = 2'b10)
  - default parameter constants (DEFAULT_DIV, FORCE_VALUE)
- Sub-module clk_div_channel: counter, div_q latch, raw-tick register. It is instantiated NUM_CH times via generate.
- The top level holds the FSM, step logic, gating, force and LED.

## Test plan
- Reset release, DEFAULT_DIV = 3, FORCE_TICKS = 1, run_i = 1:
  - tick_o[0] rises at edges 3, 6, 9…
  - force_o falls at edge 3; force_addr_o goes 7FFF → 0.
  - state_o goes 00 → 01 at edge 3.
  - clk_o[0] period is 6.
- div_i[1] changed 3 → 5 mid-period: the current period completes at 3, and subsequent periods are 5. Channel 0 is unaffected.
- run_i = 0 after FORCE:
  - no tick_o[0] pulses for 50 cycles
  - one step_i edge → exactly one pulse at the next wrap
  - two edges within one period → still one pulse
- div_i[0] = 0 and = 1: both give tick_o[0] high every cycle.
- init asserted mid-RUN with clk_o = 1: outputs return to their reset values within the same cycle without a clock edge. After release, the sequence repeats the first test.
- FORCE_TICKS = 3, LED_TICKS = 2:
  - force_o stays high through three channel-0 ticks.
  - led_o toggles on every second passed tick.
